// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one dual-port RAM (independent read and write ports, 1-cycle
//   registered read) between two requesters. Each RAM port has its own
//   round-robin arbiter, so one write and one read can issue per cycle.
//   Each read is tagged with its requester, and the response returns one
//   cycle after acceptance. A read that targets the address being written
//   in the same cycle is either stalled for one cycle or forwarded,
//   depending on the build.
//
//   Optional feature macro: RAM_ARB_FWD_EN
//     undefined : a conflicting read is held off for one cycle and then
//                 reads the freshly written RAM word.
//     defined   : a conflicting read is accepted at once, and the write
//                 data is forwarded to rsp_data on the next cycle.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   req_valid/ready/write     per-requester handshake and read/write select
//   req_addr, req_wdata       packed payloads, requester i at slice i
//   rsp_valid, rsp_data       one-cycle read response, tagged by requester
//   ram_write, ram_wr_address, ram_data_in   RAM write port
//   ram_read, ram_rd_address, ram_data_out   RAM read port
module ram_port_arbiter #(
   parameter int RAM_WIDTH = 64,
   parameter int ADDR_SIZE = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0]             req_write,
   input  logic [2*ADDR_SIZE-1:0] req_addr,
   input  logic [2*RAM_WIDTH-1:0] req_wdata,
   output logic [1:0]             rsp_valid,
   output logic [RAM_WIDTH-1:0]   rsp_data,
   output logic                   ram_write,
   output logic [ADDR_SIZE-1:0]   ram_wr_address,
   output logic [RAM_WIDTH-1:0]   ram_data_in,
   output logic                   ram_read,
   output logic [ADDR_SIZE-1:0]   ram_rd_address,
   input  logic [RAM_WIDTH-1:0]   ram_data_out
);

   logic [ADDR_SIZE-1:0] addr_arr  [2];
   logic [RAM_WIDTH-1:0] wdata_arr [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_SIZE +: ADDR_SIZE];
         assign wdata_arr[gi] = req_wdata[gi*RAM_WIDTH +: RAM_WIDTH];
      end
   endgenerate

   logic       wr_pri_reg;
   logic       rd_pri_reg;
   logic [1:0] rsp_valid_reg;

   logic [1:0] wr_cand;
   logic [1:0] rd_cand;
   logic       wr_any;
   logic       rd_any;
   logic       wr_gnt;
   logic       rd_gnt;
   logic       hazard;
   logic       rd_go;

   // With two contenders the priority pointer decides. With one, that
   // requester wins. The result is ignored when there are no candidates.
   function automatic logic pick(input logic [1:0] cand, input logic pri);
      if (cand == 2'b11)
         return pri;
      else
         return cand[1];
   endfunction

   assign wr_cand = req_valid & req_write;
   assign rd_cand = req_valid & ~req_write;
   assign wr_any  = |wr_cand;
   assign rd_any  = |rd_cand;
   assign wr_gnt  = pick(wr_cand, wr_pri_reg);
   assign rd_gnt  = pick(rd_cand, rd_pri_reg);

   // The RAM returns the old word on a same-cycle read/write to one address.
   assign hazard = wr_any & rd_any & (addr_arr[wr_gnt] == addr_arr[rd_gnt]);

`ifdef RAM_ARB_FWD_EN
   logic                 fwd_sel_reg;
   logic [RAM_WIDTH-1:0] fwd_data_reg;

   assign rd_go = rd_any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_sel_reg  <= 1'b0;
         fwd_data_reg <= '0;
      end else begin
         fwd_sel_reg <= rd_go & hazard;
         if (rd_go & hazard)
            fwd_data_reg <= wdata_arr[wr_gnt];
      end
   end

   assign rsp_data = fwd_sel_reg ? fwd_data_reg : ram_data_out;
`else
   // Holding the read back one cycle lets the RAM commit the write first.
   assign rd_go    = rd_any & ~hazard;
   assign rsp_data = ram_data_out;
`endif

   always_comb begin
      req_ready      = 2'b00;
      ram_write      = 1'b0;
      ram_read       = 1'b0;
      ram_wr_address = addr_arr[wr_gnt];
      ram_data_in    = wdata_arr[wr_gnt];
      ram_rd_address = addr_arr[rd_gnt];
      // Handshakes and RAM strobes stay quiet while reset is asserted.
      if (rst_n) begin
         if (wr_any) begin
            ram_write         = 1'b1;
            req_ready[wr_gnt] = 1'b1;
         end
         if (rd_go) begin
            ram_read          = 1'b1;
            req_ready[rd_gnt] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_pri_reg    <= 1'b0;
         rd_pri_reg    <= 1'b0;
         rsp_valid_reg <= 2'b00;
      end else begin
         if (wr_any)
            wr_pri_reg <= ~wr_gnt;
         if (rd_go)
            rd_pri_reg <= ~rd_gnt;
         // The response tag is a one-hot copy of the read grant.
         rsp_valid_reg <= rd_go ? {rd_gnt, ~rd_gnt} : 2'b00;
      end
   end

   assign rsp_valid = rsp_valid_reg;

endmodule
